instr_fetch_unit: RTL

//   PC-side initiator for the combinational instruction memory. Drives addr_from_pc, captures the

---
 rtl/instr_fetch_unit_pkg.sv | 31 +++
 rtl/instr_fetch_unit_fifo.sv | 80 ++++++++
 rtl/instr_fetch_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_pkg
//   Shared definitions for the instruction fetch unit: fetch FSM state
//   encodings, the EBREAK opcode that halts fetching, the instruction width
//   and the {pc, instr} record held by the prefetch FIFO.
//   No ports (package).
// ----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

    // One prefetch slot: the PC the word was fetched from and the word itself.
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] alignPc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous prefetch FIFO of 64-bit {pc, instr} entries.
//   Supports simultaneous push and pop when full (occupancy unchanged) and a
//   flush that empties it in one cycle, taking priority over push and pop.
//   The head entry is presented combinationally and reads as zero when empty.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (FIFO empty)
//   push     in   write wr_data at the tail
//   pop      in   drop the head entry
//   flush    in   discard all entries
//   wr_data  in   entry to write
//   rd_data  out  head entry (zero when empty)
//   full     out  DEPTH entries held
//   empty    out  no entries held
//   count    out  number of entries held (0..DEPTH)
// ----------------------------------------------------------------------------
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wr_data,
    output fetch_entry_t           rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t r_mem [DEPTH];
    logic [AW:0]  r_wrPtr;
    logic [AW:0]  r_rdPtr;
    logic         w_doPush;
    logic         w_doPop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count = r_wrPtr - r_rdPtr;
    assign empty = (r_wrPtr == r_rdPtr);
    assign full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

    // A pop frees a slot in the same cycle, so push into a full FIFO is
    // allowed when it coincides with a pop.
    assign w_doPop  = pop && !empty && !flush;
    assign w_doPush = push && !flush && (!full || w_doPop);

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    assign rd_data = empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   PC-side initiator for a combinational instruction memory. Drives the
//   fetch address, captures the returned word, buffers {pc, instr} pairs in a
//   prefetch FIFO and hands them to decode over valid/ready. Accepts
//   branch/jump redirects (flush + restart) and halts after fetching EBREAK.
// Parameters:
//   RESET_PC    PC after reset (word aligned)
//   FIFO_DEPTH  prefetch entries (power of 2, >= 2)
// Ports:
//   clk, rst        clock / asynchronous active-high reset
//   fetch_en        fetching permitted
//   addr_from_pc    byte address to instruction memory (current PC)
//   instruction     memory read data for addr_from_pc, same cycle
//   redirect_valid  pulse: flush and restart at redirect_pc
//   redirect_pc     new fetch address
//   dec_valid       head entry available to decode
//   dec_ready       decode accepts the head entry
//   dec_instr       head instruction (0 when FIFO empty)
//   dec_pc          head PC (0 when FIFO empty)
//   halted          fetch halted after EBREAK
//   misalign_err    pulse: last redirect target was not word aligned
// Optional feature, macro FETCH_PERF_EN:
//   perf_fetch_cnt  pushes into the FIFO (wrapping)
//   perf_stall_cnt  running cycles blocked by a full FIFO (wrapping)
// ----------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    output logic [31:0]        addr_from_pc,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [31:0]        dec_pc,
    output logic               halted,
    output logic               misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  r_state;
    fetch_state_e  w_stateNext;
    logic [31:0]   r_pc;
    logic          r_misalign;

    logic          w_push;
    logic          w_pop;
    logic          w_hasRoom;
    logic          w_isEbreak;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_wrEntry;
    fetch_entry_t  w_head;

    // Decode never sees an entry in a redirect cycle: the FIFO is being
    // flushed, so whatever sits at the head is already stale.
    assign dec_valid = !w_empty && !redirect_valid;
    assign w_pop     = dec_valid && dec_ready;

    assign w_hasRoom  = (w_count < CW'(FIFO_DEPTH));
    assign w_isEbreak = (instruction == EBREAK_INSTR);

    // Push only while running, enabled and not redirecting. A pop in the same
    // cycle frees a slot, so a full FIFO can still accept the new word.
    assign w_push = (r_state == S_RUN) && fetch_en && !redirect_valid &&
                    (w_hasRoom || w_pop);

    assign w_wrEntry = '{pc: r_pc, instr: instruction};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (redirect_valid),
        .wr_data (w_wrEntry),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign dec_instr    = w_head.instr;
    assign dec_pc       = w_head.pc;
    assign addr_from_pc = r_pc;
    assign halted       = (r_state == S_HALT);
    assign misalign_err = r_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Halt is left only by a redirect; the EBREAK word itself is pushed so
    // decode still receives it before fetching stops.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (fetch_en) begin
                    w_stateNext = S_RUN;
                end
            end
            S_RUN: begin
                if (redirect_valid) begin
                    w_stateNext = fetch_en ? S_RUN : S_IDLE;
                end else if (w_push && w_isEbreak) begin
                    w_stateNext = S_HALT;
                end else if (!fetch_en) begin
                    w_stateNext = S_IDLE;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    w_stateNext = fetch_en ? S_RUN : S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // The PC advances only when a word is actually accepted into the FIFO,
    // so after EBREAK it rests on the following word address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= alignPc(redirect_pc);
        end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // Registered so the error pulse lines up with the realigned PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perfFetch;
    logic [31:0] r_perfStall;

    // A stall is a cycle where fetching wanted to push but the FIFO was full
    // and nothing drained to make room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perfFetch <= '0;
            r_perfStall <= '0;
        end else begin
            if (w_push) begin
                r_perfFetch <= r_perfFetch + 32'd1;
            end
            if ((r_state == S_RUN) && fetch_en && !redirect_valid &&
                w_full && !w_pop) begin
                r_perfStall <= r_perfStall + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perfFetch;
    assign perf_stall_cnt = r_perfStall;
`else
    // Full is only needed for stall accounting; the name keeps lint quiet.
    logic w_unusedFull;
    assign w_unusedFull = w_full;
`endif

endmodule
